// File: rtl/imem_pkg.sv
// Shared constants and types for the instruction line responder.
package imem_pkg;

  // RISC-V "addi x0, x0, 0": returned whenever the fetch data is not valid.
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  // Default number of 32-bit words per line.
  localparam int DEFAULT_LINE_WORDS = 4;

  // Responder control states.
  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } state_e;

  // Number of word-offset bits within a line.
  function automatic int off_bits(input int line_words);
    return $clog2(line_words);
  endfunction

endpackage

// File: rtl/imem_line_buffer.sv
// Single instruction line: word storage with one write port, an
// asynchronous read port, and the valid/tag registers for the line.
module imem_line_buffer
  import imem_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int IDX_WIDTH  = 2,
  parameter int TAG_WIDTH  = 28
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 we,
  input  logic [IDX_WIDTH-1:0] wr_idx,
  input  logic [31:0]          wr_data,
  input  logic [IDX_WIDTH-1:0] rd_idx,
  output logic [31:0]          rd_data,
  input  logic                 load,
  input  logic [TAG_WIDTH-1:0] load_tag,
  input  logic                 load_valid,
  input  logic                 invalidate,
  output logic                 valid,
  output logic [TAG_WIDTH-1:0] tag
);

  logic [31:0]          words_r [LINE_WORDS];
  logic                 valid_r;
  logic [TAG_WIDTH-1:0] tag_r;

  // Word storage: every word powers up as a NOP, beats land at wr_idx.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LINE_WORDS; i++) begin
        words_r[i] <= NOP_INSN;
      end
    end else if (we) begin
      words_r[wr_idx] <= wr_data;
    end else begin
      words_r[wr_idx] <= words_r[wr_idx];
    end
  end

  // Line state: invalidation wins over a tag load; a load may still leave
  // the line invalid when a flush was seen while it was being filled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_r <= 1'b0;
      tag_r   <= '0;
    end else if (invalidate) begin
      valid_r <= 1'b0;
    end else if (load) begin
      valid_r <= load_valid;
      tag_r   <= load_tag;
    end else begin
      valid_r <= valid_r;
    end
  end

  assign rd_data = words_r[rd_idx];
  assign valid   = valid_r;
  assign tag     = tag_r;

endmodule

// File: rtl/imem_line_responder.sv
// Fetch-side instruction responder: serves hits from a single line buffer
// with zero wait states and refills the whole line from the external bus,
// one req/ack beat per word, on a miss.
module imem_line_responder
  import imem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WORDS = DEFAULT_LINE_WORDS,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_data,
  output logic                  mem_ready,
  input  logic                  flush,
  output logic                  ext_req,
  output logic [ADDR_WIDTH-1:0] ext_addr,
  input  logic                  ext_ack,
  input  logic [31:0]           ext_rdata,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  miss_count
);

  localparam int OFF       = off_bits(LINE_WORDS);
  localparam int TAG_WIDTH = ADDR_WIDTH - OFF - 2;
  localparam logic [OFF-1:0] LAST_BEAT = OFF'(LINE_WORDS - 1);

  state_e                state_r;
  logic [TAG_WIDTH-1:0]  base_tag_r;
  logic [OFF-1:0]        cnt_r;
  logic                  ext_req_r;
  logic [ADDR_WIDTH-1:0] ext_addr_r;
  logic                  busy_r;
  logic                  flush_pend_r;
  logic [CNT_WIDTH-1:0]  miss_count_r;

  logic [TAG_WIDTH-1:0]  addr_tag_s;
  logic [OFF-1:0]        addr_idx_s;
  logic                  unused_addr_bits_s;
  logic                  line_valid_s;
  logic [TAG_WIDTH-1:0]  line_tag_s;
  logic [31:0]           line_rdata_s;
  logic                  hit_s;
  logic                  beat_s;
  logic                  last_beat_s;
  logic                  load_valid_s;
  logic                  invalidate_s;
  logic [OFF-1:0]        cnt_next_s;

  assign addr_tag_s         = mem_addr[ADDR_WIDTH-1:OFF+2];
  assign addr_idx_s         = mem_addr[OFF+1:2];
  assign unused_addr_bits_s = ^mem_addr[1:0];
  assign cnt_next_s         = cnt_r + {{(OFF-1){1'b0}}, 1'b1};

  imem_line_buffer #(
    .LINE_WORDS (LINE_WORDS),
    .IDX_WIDTH  (OFF),
    .TAG_WIDTH  (TAG_WIDTH)
  ) u_line (
    .clk        (clk),
    .reset_n    (reset_n),
    .we         (beat_s),
    .wr_idx     (cnt_r),
    .wr_data    (ext_rdata),
    .rd_idx     (addr_idx_s),
    .rd_data    (line_rdata_s),
    .load       (last_beat_s),
    .load_tag   (base_tag_r),
    .load_valid (load_valid_s),
    .invalidate (invalidate_s),
    .valid      (line_valid_s),
    .tag        (line_tag_s)
  );

  // Hit detection and the same-cycle fetch response.
  always_comb begin
    hit_s     = 1'b0;
    mem_ready = 1'b0;
    mem_data  = NOP_INSN;
    if ((state_r == IDLE) && line_valid_s && (line_tag_s == addr_tag_s) && !flush) begin
      hit_s     = 1'b1;
      mem_ready = 1'b1;
      mem_data  = line_rdata_s;
    end else begin
      hit_s     = 1'b0;
      mem_ready = 1'b0;
      mem_data  = NOP_INSN;
    end
  end

  // Line buffer control: beats only count in REFILL (acks in IDLE are
  // ignored); a flush seen at any point of the refill keeps the line invalid.
  always_comb begin
    beat_s       = 1'b0;
    last_beat_s  = 1'b0;
    load_valid_s = !(flush_pend_r || flush);
    invalidate_s = 1'b0;
    if (state_r == REFILL) begin
      beat_s      = ext_ack;
      last_beat_s = ext_ack && (cnt_r == LAST_BEAT);
    end else begin
      invalidate_s = !hit_s;
    end
  end

  // Refill sequencer, beat handshake and saturating miss counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      base_tag_r   <= '0;
      cnt_r        <= '0;
      ext_req_r    <= 1'b0;
      ext_addr_r   <= '0;
      busy_r       <= 1'b0;
      flush_pend_r <= 1'b0;
      miss_count_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (flush) begin
            state_r <= IDLE;
          end else if (!hit_s) begin
            state_r      <= REFILL;
            base_tag_r   <= addr_tag_s;
            cnt_r        <= '0;
            ext_req_r    <= 1'b1;
            ext_addr_r   <= {addr_tag_s, {(OFF + 2){1'b0}}};
            busy_r       <= 1'b1;
            flush_pend_r <= 1'b0;
            if (miss_count_r != {CNT_WIDTH{1'b1}}) begin
              miss_count_r <= miss_count_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end else begin
              miss_count_r <= miss_count_r;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        REFILL: begin
          if (flush) begin
            flush_pend_r <= 1'b1;
          end else begin
            flush_pend_r <= flush_pend_r;
          end
          if (ext_ack) begin
            cnt_r      <= cnt_next_s;
            ext_addr_r <= {base_tag_r, cnt_next_s, 2'b00};
            if (cnt_r == LAST_BEAT) begin
              state_r      <= IDLE;
              ext_req_r    <= 1'b0;
              busy_r       <= 1'b0;
              flush_pend_r <= 1'b0;
            end else begin
              state_r <= REFILL;
            end
          end else begin
            state_r <= REFILL;
          end
        end
        default: begin
          state_r   <= IDLE;
          ext_req_r <= 1'b0;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

  assign ext_req    = ext_req_r;
  assign ext_addr   = ext_addr_r;
  assign busy       = busy_r;
  assign miss_count = miss_count_r;

endmodule
